rv32i_datapath_core: RTL and testbench

- Architectural-state and arithmetic core of the 5-stage RV32I pipeline.
- Bundles three parts:
  - the program-counter register with stall hold and +4 incrementer;
  - the 32x32 integer register file (2 read ports, 1 write port);
  - the combinational ALU with branch-condition output.
- Fetch uses pc/pc_plus4; decode reads the RF; EX drives the ALU; writeback writes the RF.

---
 rtl/rv32i_datapath_core.sv | 123 ++++++++++++
 tb/tb_rv32i_datapath_core.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_datapath_core.sv
// Architectural-state and arithmetic core of the RV32I pipeline:
// PC register with +4, 32x32 register file with write-first bypass, and ALU.
module rv32i_datapath_core #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_ni,
  input  logic            pc_stall,
  input  logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            rf_we,
  input  logic [4:0]      rf_waddr,
  input  logic [XLEN-1:0] rf_wdata,
  input  logic [4:0]      rf_raddr1,
  input  logic [4:0]      rf_raddr2,
  output logic [XLEN-1:0] rf_rdata1,
  output logic [XLEN-1:0] rf_rdata2,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  input  logic [3:0]      alu_op,
  input  logic            alu_us,
  output logic [XLEN-1:0] alu_y,
  output logic            alu_zero
);

  localparam int unsigned NREGS = 32;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_PASSB = 4'd9;
  localparam logic [3:0] OP_BEQ   = 4'd10;
  localparam logic [3:0] OP_BNE   = 4'd11;
  localparam logic [3:0] OP_BLT   = 4'd12;
  localparam logic [3:0] OP_BGE   = 4'd13;

  // Program counter
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      pc <= RESET_PC;
    end else if (!pc_stall) begin
      pc <= pc_next;
    end
  end

  assign pc_plus4 = pc + XLEN'(4);

  // Register file; x0 is never written so it stays zero
  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  assign wr_en = rf_we && (rf_waddr != 5'd0);

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // Write-first bypass lets writeback and decode share a cycle
  always_comb begin
    rf_rdata1 = '0;
    rf_rdata2 = '0;
    if (rf_raddr1 != 5'd0) begin
      rf_rdata1 = (wr_en && (rf_waddr == rf_raddr1)) ? rf_wdata : regs[rf_raddr1];
    end
    if (rf_raddr2 != 5'd0) begin
      rf_rdata2 = (wr_en && (rf_waddr == rf_raddr2)) ? rf_wdata : regs[rf_raddr2];
    end
  end

  // ALU
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [4:0]      shamt;
  logic            lt;

  assign sum   = alu_a + alu_b;
  assign diff  = alu_a - alu_b;
  assign shamt = alu_b[4:0];
  assign lt    = alu_us ? (alu_a < alu_b) : ($signed(alu_a) < $signed(alu_b));

  always_comb begin
    alu_y    = '0;
    alu_zero = 1'b0;
    unique case (alu_op)
      OP_ADD:   alu_y = sum;
      OP_SUB:   alu_y = diff;
      OP_AND:   alu_y = alu_a & alu_b;
      OP_OR:    alu_y = alu_a | alu_b;
      OP_XOR:   alu_y = alu_a ^ alu_b;
      OP_SLL:   alu_y = alu_a << shamt;
      OP_SRL:   alu_y = alu_a >> shamt;
      OP_SRA:   alu_y = XLEN'($signed(alu_a) >>> shamt);
      OP_SLT:   alu_y = XLEN'(lt);
      OP_PASSB: alu_y = alu_b;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE: alu_y = diff;
      default:  alu_y = '0;
    endcase
    // Branch ops report the condition; arithmetic ops report y == 0; reserved ops report 0
    unique case (alu_op)
      OP_BEQ:  alu_zero = (alu_a == alu_b);
      OP_BNE:  alu_zero = (alu_a != alu_b);
      OP_BLT:  alu_zero = lt;
      OP_BGE:  alu_zero = !lt;
      4'd14, 4'd15: alu_zero = 1'b0;
      default: alu_zero = (alu_y == '0);
    endcase
  end

endmodule

// File: tb/tb_rv32i_datapath_core.sv
// Self-checking bench for rv32i_datapath_core: ALU vector table plus
// directed PC, register-file and reset sequences.
module tb_rv32i_datapath_core;

  logic        clk;
  logic        reset_ni;
  logic        pc_stall;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic        alu_us;
  logic [31:0] alu_y;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;

  rv32i_datapath_core #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_ni(reset_ni), .pc_stall(pc_stall), .pc_next(pc_next),
    .pc(pc), .pc_plus4(pc_plus4), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_us(alu_us), .alu_y(alu_y), .alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        us;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_y;
    logic        exp_zero;
  } alu_vec_t;

  localparam int NVEC = 22;
  alu_vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{4'd0,  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[1]  = '{4'd0,  1'b1, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0};
    vecs[2]  = '{4'd1,  1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{4'd2,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
    vecs[4]  = '{4'd3,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0};
    vecs[5]  = '{4'd4,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0};
    vecs[6]  = '{4'd5,  1'b0, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0};
    vecs[7]  = '{4'd6,  1'b0, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0};
    vecs[8]  = '{4'd7,  1'b0, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0};
    vecs[9]  = '{4'd7,  1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFE1, 32'h3FFF_FFFF, 1'b0};
    vecs[10] = '{4'd8,  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[11] = '{4'd8,  1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[12] = '{4'd9,  1'b0, 32'h0000_0123, 32'hABCD_E000, 32'hABCD_E000, 1'b0};
    vecs[13] = '{4'd10, 1'b0, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1};
    vecs[14] = '{4'd11, 1'b0, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b0};
    vecs[15] = '{4'd12, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1};
    vecs[16] = '{4'd12, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[17] = '{4'd13, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1};
    vecs[18] = '{4'd13, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[19] = '{4'd14, 1'b0, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b0};
    vecs[20] = '{4'd15, 1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b0};
    vecs[21] = '{4'd11, 1'b0, 32'h0000_0007, 32'h0000_0009, 32'hFFFF_FFFE, 1'b1};

    reset_ni  = 1'b0;
    pc_stall  = 1'b1;
    pc_next   = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    alu_us    = 1'b0;

    #3;
    chk("reset pc", pc, 32'h0000_0000);
    chk("reset pc_plus4", pc_plus4, 32'h0000_0004);
    @(negedge clk);
    reset_ni = 1'b1;

    // ALU table
    for (int i = 0; i < NVEC; i++) begin
      alu_op = vecs[i].op;
      alu_us = vecs[i].us;
      alu_a  = vecs[i].a;
      alu_b  = vecs[i].b;
      #1;
      chk($sformatf("alu[%0d] op%0d y", i, vecs[i].op), alu_y, vecs[i].exp_y);
      chk($sformatf("alu[%0d] op%0d zero", i, vecs[i].op), 32'(alu_zero), 32'(vecs[i].exp_zero));
    end

    // PC update, stall, wrap
    @(negedge clk);
    pc_stall = 1'b0;
    pc_next  = 32'h0000_0100;
    @(posedge clk); #1;
    chk("pc load", pc, 32'h0000_0100);
    chk("pc_plus4 after load", pc_plus4, 32'h0000_0104);
    pc_next  = 32'h0000_0200;
    pc_stall = 1'b1;
    @(posedge clk); #1;
    chk("pc stall hold", pc, 32'h0000_0100);
    pc_stall = 1'b0;
    pc_next  = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    chk("pc wrap value", pc, 32'hFFFF_FFFC);
    chk("pc_plus4 wrap", pc_plus4, 32'h0000_0000);
    pc_stall = 1'b1;
    pc_next  = 32'h0000_0002;
    @(posedge clk); #1;
    chk("pc stall hold 2", pc, 32'hFFFF_FFFC);

    // RF write with same-cycle bypass
    @(negedge clk);
    rf_we = 1'b1; rf_waddr = 5'd5; rf_wdata = 32'hDEAD_BEEF;
    rf_raddr1 = 5'd5; rf_raddr2 = 5'd6;
    #1;
    chk("rf bypass port1", rf_rdata1, 32'hDEAD_BEEF);
    chk("rf no bypass port2", rf_rdata2, 32'h0000_0000);
    @(posedge clk); #1;
    rf_we = 1'b0; rf_wdata = 32'h0;
    #1;
    chk("rf x5 stored", rf_rdata1, 32'hDEAD_BEEF);

    // Write to x0 is ignored, also on the bypass path
    @(negedge clk);
    rf_we = 1'b1; rf_waddr = 5'd0; rf_wdata = 32'h0000_1234;
    rf_raddr1 = 5'd0; rf_raddr2 = 5'd0;
    #1;
    chk("rf x0 bypass", rf_rdata1, 32'h0000_0000);
    @(posedge clk); #1;
    rf_we = 1'b0;
    #1;
    chk("rf x0 port1", rf_rdata1, 32'h0000_0000);
    chk("rf x0 port2", rf_rdata2, 32'h0000_0000);

    // Bypass on port 2, then both ports read the same register
    @(negedge clk);
    rf_we = 1'b1; rf_waddr = 5'd31; rf_wdata = 32'h0000_0055;
    rf_raddr1 = 5'd5; rf_raddr2 = 5'd31;
    #1;
    chk("rf bypass port2", rf_rdata2, 32'h0000_0055);
    chk("rf port1 during write", rf_rdata1, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    rf_we = 1'b0;
    rf_raddr1 = 5'd5; rf_raddr2 = 5'd5;
    #1;
    chk("rf same addr port1", rf_rdata1, 32'hDEAD_BEEF);
    chk("rf same addr port2", rf_rdata2, 32'hDEAD_BEEF);
    rf_raddr1 = 5'd31;
    #1;
    chk("rf x31 stored", rf_rdata1, 32'h0000_0055);

    // Mid-cycle reset with a pending PC update and RF write
    @(negedge clk);
    #2;
    pc_stall = 1'b0; pc_next = 32'h0000_0300;
    rf_we = 1'b1; rf_waddr = 5'd7; rf_wdata = 32'h7777_7777;
    reset_ni = 1'b0;
    #1;
    chk("async reset pc", pc, 32'h0000_0000);
    chk("async reset pc_plus4", pc_plus4, 32'h0000_0004);
    @(posedge clk); #1;
    chk("reset overrides pc update", pc, 32'h0000_0000);
    rf_we = 1'b0;
    for (int r = 0; r < 32; r++) begin
      rf_raddr1 = 5'(r);
      rf_raddr2 = 5'(31 - r);
      #1;
      chk($sformatf("reset rdata1 x%0d", r), rf_rdata1, 32'h0000_0000);
      chk($sformatf("reset rdata2 x%0d", 31 - r), rf_rdata2, 32'h0000_0000);
    end

    // First edge after release performs a normal update
    @(negedge clk);
    reset_ni = 1'b1;
    @(posedge clk); #1;
    chk("pc after release", pc, 32'h0000_0300);
    chk("pc_plus4 after release", pc_plus4, 32'h0000_0304);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
